// File: rtl/shifter_8bit_piso_pkg.sv
// shifter_8bit_piso_pkg: shared widths, direction constants and state encoding
package shifter_8bit_piso_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 3;
  localparam logic DIR_LEFT = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;
endpackage

// File: rtl/shifter_8bit_piso.sv
// shifter_8bit_piso: parallel-in/serial-out shifter with valid/ready on both sides
module shifter_8bit_piso
  import shifter_8bit_piso_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic [CNT_W-1:0] n,
  input  logic             dir,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  input  logic             ser_ready,
  output logic             busy
);
  state_t state;
  logic [WIDTH-1:0] sreg;
  logic [CNT_W-1:0] cnt;
  logic dir_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      sreg  <= '0;
      cnt   <= '0;
      dir_q <= DIR_LEFT;
    end else if (state == S_IDLE) begin
      if (load_valid) begin
        sreg  <= data_in;
        cnt   <= n;
        dir_q <= dir;
        state <= S_SHIFT;
      end
    end else if (ser_ready) begin
      sreg <= (dir_q == DIR_RIGHT) ? sreg >> 1 : sreg << 1;
      if (cnt == '0) state <= S_IDLE;
      else cnt <= cnt - 1'b1;
    end
  end
  // outputs decode registers only; load_ready additionally masked by reset
  assign load_ready = (state == S_IDLE) && !rst;
  assign ser_valid  = (state == S_SHIFT);
  assign busy       = (state == S_SHIFT);
  assign ser_last   = (state == S_SHIFT) && (cnt == '0);
  assign ser_out    = (state == S_SHIFT) && ((dir_q == DIR_RIGHT) ? sreg[0] : sreg[WIDTH-1]);
endmodule

// File: tb/tb_shifter_8bit_piso.sv
// tb_shifter_8bit_piso: randomized scenario bench against a bit-list reference model
module tb_shifter_8bit_piso;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] data_in = '0;
  logic [2:0] n = '0;
  logic dir = 1'b0;
  logic load_valid = 1'b0;
  logic ser_ready = 1'b0;
  logic load_ready, ser_out, ser_valid, ser_last, busy;
  int vecs = 0;
  int errs = 0;

  shifter_8bit_piso dut (
    .clk(clk), .rst(rst), .data_in(data_in), .n(n), .dir(dir),
    .load_valid(load_valid), .load_ready(load_ready), .ser_out(ser_out),
    .ser_valid(ser_valid), .ser_last(ser_last), .ser_ready(ser_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // expected stream: the first n+1 bits in send order, last flag on the final one
  task automatic run_word(input logic [7:0] w, input logic [2:0] nn, input logic d,
                          input int pct, input bit hold, input int abort);
    logic exp_q[$];
    int idx = 0;
    int cyc = 0;
    for (int i = 0; i <= int'(nn); i++) exp_q.push_back(d ? w[i] : w[7-i]);
    data_in = w; n = nn; dir = d; load_valid = 1'b1; ser_ready = 1'b0;
    @(posedge clk); #1;
    load_valid = hold;
    while (idx <= int'(nn) && !(abort > 0 && idx == abort) && cyc < 300) begin
      ser_ready = ($urandom_range(0, 99) < pct);
      if (hold) begin
        data_in = 8'($urandom); n = 3'($urandom); dir = 1'($urandom);
      end
      @(negedge clk);
      vecs++;
      if (ser_valid !== 1'b1 || busy !== 1'b1 || load_ready !== 1'b0 ||
          ser_out !== exp_q[idx] || ser_last !== (idx == int'(nn))) begin
        errs++;
        $display("FAIL beat%0d w=%h n=%0d d=%b: got v=%b busy=%b lr=%b out=%b last=%b, want v=1 busy=1 lr=0 out=%b last=%b",
                 idx, w, nn, d, ser_valid, busy, load_ready, ser_out, ser_last, exp_q[idx], idx == int'(nn));
      end
      if (ser_ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    load_valid = 1'b0;
    ser_ready = 1'b0;
    if (cyc >= 300) begin
      errs++;
      $display("FAIL timeout w=%h: got %0d beats, want %0d", w, idx, int'(nn) + 1);
    end
    if (abort == 0) begin
      @(negedge clk);
      vecs++;
      if (ser_valid !== 1'b0 || busy !== 1'b0 || load_ready !== 1'b1 || ser_last !== 1'b0) begin
        errs++;
        $display("FAIL bubble w=%h: got v=%b busy=%b lr=%b last=%b, want v=0 busy=0 lr=1 last=0",
                 w, ser_valid, busy, load_ready, ser_last);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; load_valid = 1'b1; data_in = 8'hA5; n = 3'd7;
    repeat (2) begin
      @(negedge clk);
      vecs++;
      if (load_ready !== 1'b0 || ser_valid !== 1'b0 || busy !== 1'b0 || ser_out !== 1'b0 || ser_last !== 1'b0) begin
        errs++;
        $display("FAIL reset_hold: got lr=%b v=%b busy=%b out=%b last=%b, want all 0",
                 load_ready, ser_valid, busy, ser_out, ser_last);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; load_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      vecs++;
      if (load_ready !== 1'b1 || ser_valid !== 1'b0 || busy !== 1'b0) begin
        errs++;
        $display("FAIL reset_release: got lr=%b v=%b busy=%b, want lr=1 v=0 busy=0",
                 load_ready, ser_valid, busy);
      end
    end
  endtask

  task automatic test_directed();
    run_word(8'b10101010, 3'd7, 1'b0, 100, 1'b0, 0);
    run_word(8'b11110000, 3'd3, 1'b1, 100, 1'b0, 0);
    run_word(8'b11001100, 3'd0, 1'b0, 100, 1'b0, 0);
  endtask

  task automatic test_backpressure();
    logic exp_b;
    run_word(8'b10000000, 3'd7, 1'b1, 100, 1'b0, 2);
    repeat (3) begin
      @(negedge clk);
      vecs++;
      exp_b = 1'b0;
      if (ser_valid !== 1'b1 || ser_out !== exp_b || ser_last !== 1'b0) begin
        errs++;
        $display("FAIL stall: got v=%b out=%b last=%b, want v=1 out=0 last=0", ser_valid, ser_out, ser_last);
      end
      @(posedge clk); #1;
    end
    for (int i = 2; i < 8; i++) begin
      ser_ready = 1'b1;
      @(negedge clk);
      vecs++;
      exp_b = (i == 7);
      if (ser_valid !== 1'b1 || ser_out !== exp_b || ser_last !== (i == 7)) begin
        errs++;
        $display("FAIL resume%0d: got v=%b out=%b last=%b, want v=1 out=%b last=%b",
                 i, ser_valid, ser_out, ser_last, exp_b, i == 7);
      end
      @(posedge clk); #1;
    end
    ser_ready = 1'b0;
  endtask

  task automatic test_reset_midword();
    run_word(8'b11111111, 3'd7, 1'b0, 100, 1'b0, 3);
    rst = 1'b1;
    @(negedge clk);
    vecs++;
    if (load_ready !== 1'b0) begin
      errs++;
      $display("FAIL midreset_lr: got lr=%b, want 0", load_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    vecs++;
    if (ser_valid !== 1'b0 || busy !== 1'b0 || ser_last !== 1'b0 || ser_out !== 1'b0 || load_ready !== 1'b1) begin
      errs++;
      $display("FAIL midreset_after: got v=%b busy=%b last=%b out=%b lr=%b, want 0 0 0 0 1",
               ser_valid, busy, ser_last, ser_out, load_ready);
    end
    run_word(8'b00000001, 3'd7, 1'b1, 100, 1'b0, 0);
  endtask

  task automatic test_hold_load();
    run_word(8'h3C, 3'd6, 1'b0, 100, 1'b1, 0);
    run_word(8'h96, 3'd5, 1'b1, 60, 1'b1, 0);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 25; k++)
      run_word(8'($urandom), 3'($urandom), 1'($urandom), $urandom_range(30, 100), 1'($urandom), 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midword();
    test_hold_load();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
